rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Shares one single-port, byte-writable synchronous RAM between NREQ requesters.
- Default wiring: port 0 = CPU instruction fetch, port 1 = CPU data load/store, port 2 = debug/DMA loader.
- Round-robin arbitration with a per-owner burst limit; each cycle at most one access issues.
- Routes read data back to the requester that issued the read, one cycle later.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 32, address width (byte address; bits [1:0] ignored on the memory side).
- MAX_BURST, 4, max consecutive grants to one requester while another requester is waiting (1..15).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NREQ  per-port access request, level, held until granted.
- req_addr  input  NREQ*AW  per-port byte address; port i at [i*AW +: AW].
- req_wdata  input  NREQ*32  per-port write data, lanes already aligned.
- req_we  input  NREQ*4  per-port byte write enables; all-zero = read.
- gnt  output  NREQ  one-hot, combinational; access issues this cycle.
- rvalid  output  NREQ  one-hot, registered; read data valid for that port.
- rdata  output  32  read data, broadcast to all ports (= mem_q).
- mem_en  output  1  memory access strobe.
- mem_addr  output  AW  word address {addr[AW-1:2],2'b00} of the granted port.
- mem_d  output  32  write data of the granted port.
- mem_we  output  4  byte enables of the granted port.
- mem_q  input  32  memory read data, valid the cycle after mem_en with mem_we==0.

Behaviour:
- State registers:
  - last: index of the most recent grantee.
  - burst_cnt: 4-bit count of consecutive grants to last.
  - rd_owner: NREQ-bit one-hot owner of the pending read.
- Reset values:
  - last = NREQ-1, so port 0 wins first.
  - burst_cnt = 0, rd_owner = 0.
  - Combinational outputs with req=0: gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_d=0.
  - rvalid=0.
- Arbitration, evaluated every cycle:
  - If req[last]=1, burst_cnt<MAX_BURST, and no other port requests: grant last.
  - If req[last]=1, burst_cnt<MAX_BURST, and others request: still grant last.
  - If req[last]=1 and burst_cnt>=MAX_BURST with no other requester: keep granting last; burst_cnt saturates at MAX_BURST.
  - Otherwise: grant the first requesting port scanning last+1, last+2, … modulo NREQ.
- On a grant to port g:
  - mem_en=1 and mem_* come from port g's inputs in the same cycle.
  - Next: last<=g; burst_cnt<=(g==last)?sat(burst_cnt+1):1.
- No grant: last holds, burst_cnt<=0.
- Read latency:
  - Grant of a read in cycle N gives rvalid[g]=1 in cycle N+1 with rdata=mem_q.
  - rd_owner<=gnt & {NREQ{req_we of g == 0}}.
  - rvalid = rd_owner.
- Writes take effect in the grant cycle. They never assert rvalid.
- Back-to-back: a new grant may issue in the same cycle as rvalid for the previous read; full throughput is 1 access/cycle.
- Requester contract: after gnt, the requester may drop or change req/addr in the next cycle. Arbiter does not latch requests.
- A request deasserted before grant is simply not served; no error.
- Reset mid-operation: rvalid forced to 0 immediately (async). A pending read is discarded and the requester must reissue.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds output stall_cnt (NREQ*16). For port i at [i*16 +: 16], a counter increments each cycle req[i]=1 && gnt[i]=0, saturates at 16'hFFFF, and is cleared by rst only.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset, then req=3'b111, all reads, held 12 cycles, MAX_BURST=4 -> grants port0 ×4, port1 ×4, port2 ×4. rvalid follows each gnt by exactly 1 cycle with matching one-hot.
- Only port1 requests, 10 consecutive reads at 0x100,0x104,… -> gnt[1]=1 all 10 cycles. burst_cnt saturates at 4 with no rotation. rdata matches preloaded words.
- Port0 read 0x40 in cycle N; port1 write 0xDEADBEEF, we=4'b0010, to 0x40 in N+1; port0 read 0x40 in N+2 -> rvalid[0] in N+1 with old data; mem_we=0010 in N+1; second read returns only byte1 changed to 0xBE.
- Port2 read granted, rst pulsed in the following cycle -> rvalid=0 immediately. After release gnt goes to port0 first when req=3'b111.
- Address 0x00000207 from port1 -> mem_addr=0x00000204.
- ARB_STATS_EN: port2 requests continuously while ports 0/1 saturate for 8 cycles, MAX_BURST=4 -> stall_cnt[2] counts exactly 8 before port2's first grant. After forcing 70000 stall cycles it holds 0xFFFF.

Source files
------------

// File: rtl/rv_mem_arbiter_if.sv
// rv_mem_arbiter_if: requester and memory-side bus bundle for rv_mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters plus the memory.
interface rv_mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32
);
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*32-1:0]   req_wdata;
    logic [NREQ*4-1:0]    req_we;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [31:0]          rdata;
    logic                 mem_en;
    logic [AW-1:0]        mem_addr;
    logic [31:0]          mem_d;
    logic [3:0]           mem_we;
    logic [31:0]          mem_q;

    modport slave (
        input  req, req_addr, req_wdata, req_we, mem_q,
        output gnt, rvalid, rdata, mem_en, mem_addr, mem_d, mem_we
    );

    modport master (
        output req, req_addr, req_wdata, req_we, mem_q,
        input  gnt, rvalid, rdata, mem_en, mem_addr, mem_d, mem_we
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: round-robin arbiter sharing one byte-writable synchronous
// RAM between NREQ requesters. Each owner gets at most MAX_BURST back-to-back
// grants while another port is waiting. Read data returns one cycle after the
// grant, and rvalid is asserted only to the port that issued the read.
// Optional build macro ARB_STATS_EN adds a saturating per-port stall counter
// output, stall_cnt.
module rv_mem_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rv_mem_arbiter_if.slave      bus
`ifdef ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stall_cnt
`endif
);

    localparam int          IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  MAX_B4 = 4'(MAX_BURST);

    logic [IW-1:0]   last_r;
    logic [3:0]      burst_cnt_r;
    logic [NREQ-1:0] rd_owner_r;

    logic [NREQ-1:0] others_s;
    logic            keep_s;
    logic            found_s;
    logic [IW-1:0]   pick_s;
    logic            any_s;
    logic [IW-1:0]   g_s;
    logic [NREQ-1:0] gnt_s;
    logic [AW-1:0]   addr_g_s;
    logic [AW-1:0]   mem_addr_s;
    logic [31:0]     mem_d_s;
    logic [3:0]      mem_we_s;
    logic [3:0]      burst_inc_s;

    // One-hot decode of a port index
    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Arbitration decision and memory-side mux for the current cycle.
    // A zero burst_cnt means the previous cycle had no grant, so the ownership
    // chain is broken and rotation resumes after last. This is why port 0 wins
    // first out of reset.
    always_comb begin
        int unsigned idx_v;
        logic        hit_v;
        others_s = bus.req & ~onehot(last_r);
        keep_s   = bus.req[last_r] && (burst_cnt_r != 4'd0) &&
                   ((burst_cnt_r < MAX_B4) || (others_s == {NREQ{1'b0}}));
        found_s  = 1'b0;
        pick_s   = last_r;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v   = (int'(last_r) + k) % NREQ;
            hit_v   = !found_s && bus.req[idx_v];
            pick_s  = hit_v ? IW'(idx_v) : pick_s;
            found_s = found_s | hit_v;
        end

        if (keep_s) begin
            any_s = 1'b1;
            g_s   = last_r;
        end else if (found_s) begin
            any_s = 1'b1;
            g_s   = pick_s;
        end else begin
            any_s = 1'b0;
            g_s   = last_r;
        end

        addr_g_s = bus.req_addr[int'(g_s)*AW +: AW];
        if (any_s) begin
            gnt_s      = onehot(g_s);
            mem_addr_s = {addr_g_s[AW-1:2], 2'b00};
            mem_d_s    = bus.req_wdata[int'(g_s)*32 +: 32];
            mem_we_s   = bus.req_we[int'(g_s)*4 +: 4];
        end else begin
            gnt_s      = {NREQ{1'b0}};
            mem_addr_s = {AW{1'b0}};
            mem_d_s    = 32'h0000_0000;
            mem_we_s   = 4'b0000;
        end

        burst_inc_s = (burst_cnt_r >= MAX_B4) ? MAX_B4 : (burst_cnt_r + 4'd1);
    end

    // Arbitration history and read-return ownership
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r      <= IW'(NREQ - 1);
            burst_cnt_r <= 4'd0;
            rd_owner_r  <= {NREQ{1'b0}};
        end else begin
            if (any_s) begin
                last_r      <= g_s;
                burst_cnt_r <= (g_s == last_r) ? burst_inc_s : 4'd1;
            end else begin
                last_r      <= last_r;
                burst_cnt_r <= 4'd0;
            end
            rd_owner_r <= (mem_we_s == 4'b0000) ? gnt_s : {NREQ{1'b0}};
        end
    end

    assign bus.gnt      = gnt_s;
    assign bus.rvalid   = rd_owner_r;
    assign bus.rdata    = bus.mem_q;
    assign bus.mem_en   = any_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_d    = mem_d_s;
    assign bus.mem_we   = mem_we_s;

`ifdef ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stall
        logic [15:0] cnt_r;

        // Count cycles this port waits with a pending request; saturates
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= 16'h0000;
            end else if (bus.req[gi] && !gnt_s[gi] && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end

        assign stall_cnt[gi*16 +: 16] = cnt_r;
    end
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed self-checking bench for rv_mem_arbiter.
// A small word-addressed RAM model answers the memory side. Expected values
// are hand-computed from the preload pattern mem[i] = 0x1000_0000 + i.
module tb_rv_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rv_mem_arbiter_if #(.NREQ(3), .AW(32)) bus ();

`ifdef ARB_STATS_EN
    logic [3*16-1:0] stall_cnt;
    logic [8*16-1:0] stall8;
    rv_mem_arbiter_if #(.NREQ(8), .AW(32)) bus8 ();
`endif

    rv_mem_arbiter #(.NREQ(3), .AW(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifdef ARB_STATS_EN
    rv_mem_arbiter #(.NREQ(8), .AW(32), .MAX_BURST(1)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus8),
        .stall_cnt (stall8)
    );
    assign bus8.mem_q = 32'h0000_0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: preload while in reset, byte writes, one-cycle read latency
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we == 4'b0000) begin
                bus.mem_q <= mem[bus.mem_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_we[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_d[b*8 +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_g;
    logic [2:0] prev_g;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req       = 3'b000;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_we    = '0;
        bus.mem_q     = 32'h0000_0000;
`ifdef ARB_STATS_EN
        bus8.req       = 8'h00;
        bus8.req_addr  = '0;
        bus8.req_wdata = '0;
        bus8.req_we    = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state with no requests
        @(negedge clk);
        check_eq("rst_gnt",      64'(bus.gnt),      64'h0);
        check_eq("rst_rvalid",   64'(bus.rvalid),   64'h0);
        check_eq("rst_mem_en",   64'(bus.mem_en),   64'h0);
        check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        check_eq("rst_mem_d",    64'(bus.mem_d),    64'h0);
        check_eq("rst_mem_we",   64'(bus.mem_we),   64'h0);
        step();

        // All three ports read for 12 cycles: 0 x4, 1 x4, 2 x4
        bus.req      = 3'b111;
        bus.req_addr = {32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
        prev_g = 3'b000;
        for (int c = 0; c < 12; c++) begin
            exp_g = 3'b001 << (c / 4);
            @(negedge clk);
            check_eq("rr_gnt",    64'(bus.gnt),    64'(exp_g));
            check_eq("rr_rvalid", 64'(bus.rvalid), 64'(prev_g));
            prev_g = exp_g;
            step();
        end
        bus.req = 3'b000;
        @(negedge clk);
        check_eq("rr_last_rvalid", 64'(bus.rvalid), 64'h4);
        check_eq("rr_last_rdata",  64'(bus.rdata),  64'h1000_0002);
        check_eq("rr_idle_gnt",    64'(bus.gnt),    64'h0);
        step();

        // Port 1 alone: 10 reads at 0x100.., no rotation
        bus.req = 3'b010;
        for (int k = 0; k < 10; k++) begin
            bus.req_addr[32 +: 32] = 32'h0000_0100 + 32'(4 * k);
            @(negedge clk);
            check_eq("solo_gnt",  64'(bus.gnt),      64'h2);
            check_eq("solo_addr", 64'(bus.mem_addr), 64'(32'h0000_0100 + 32'(4 * k)));
            if (k > 0) begin
                check_eq("solo_rvalid", 64'(bus.rvalid), 64'h2);
                check_eq("solo_rdata",  64'(bus.rdata),  64'(32'h1000_0040 + 32'(k - 1)));
            end
            step();
        end
        bus.req = 3'b000;
        @(negedge clk);
        check_eq("solo_end_rvalid", 64'(bus.rvalid), 64'h2);
        check_eq("solo_end_rdata",  64'(bus.rdata),  64'h1000_0049);
        step();

        // Read / byte-write / read to 0x40
        bus.req_addr = {32'h0000_0000, 32'h0000_0040, 32'h0000_0040};
        bus.req_wdata[32 +: 32] = 32'hDEAD_BEEF;
        bus.req = 3'b001;
        @(negedge clk);
        check_eq("rw_gnt0",  64'(bus.gnt),    64'h1);
        check_eq("rw_we0",   64'(bus.mem_we), 64'h0);
        step();
        bus.req = 3'b010;
        bus.req_we[4 +: 4] = 4'b0010;
        @(negedge clk);
        check_eq("rw_gnt1",    64'(bus.gnt),    64'h2);
        check_eq("rw_we1",     64'(bus.mem_we), 64'h2);
        check_eq("rw_d1",      64'(bus.mem_d),  64'hDEAD_BEEF);
        check_eq("rw_rvalid0", 64'(bus.rvalid), 64'h1);
        check_eq("rw_old",     64'(bus.rdata),  64'h1000_0010);
        step();
        bus.req = 3'b001;
        bus.req_we[4 +: 4] = 4'b0000;
        @(negedge clk);
        check_eq("rw_gnt2",      64'(bus.gnt),    64'h1);
        check_eq("rw_wr_norv",   64'(bus.rvalid), 64'h0);
        step();
        bus.req = 3'b000;
        @(negedge clk);
        check_eq("rw_rvalid2", 64'(bus.rvalid), 64'h1);
        check_eq("rw_new",     64'(bus.rdata),  64'h1000_BE10);
        step();

        // Reset during a pending read return
        bus.req_addr[64 +: 32] = 32'h0000_0010;
        bus.req = 3'b100;
        @(negedge clk);
        check_eq("rs_gnt2", 64'(bus.gnt), 64'h4);
        step();
        bus.req = 3'b000;
        check_eq("rs_pre_rvalid", 64'(bus.rvalid), 64'h4);
        rst = 1'b1;
        #1;
        check_eq("rs_rvalid_clr", 64'(bus.rvalid), 64'h0);
        step();
        rst = 1'b0;
        bus.req = 3'b111;
        @(negedge clk);
        check_eq("rs_first_gnt", 64'(bus.gnt), 64'h1);
        step();

        // Unaligned byte address is word-aligned on the memory side
        bus.req = 3'b010;
        bus.req_addr[32 +: 32] = 32'h0000_0207;
        @(negedge clk);
        check_eq("al_gnt",  64'(bus.gnt),      64'h2);
        check_eq("al_addr", 64'(bus.mem_addr), 64'h0000_0204);
        step();
        bus.req = 3'b000;
        @(negedge clk);
        check_eq("al_idle_en",   64'(bus.mem_en),   64'h0);
        check_eq("al_idle_addr", 64'(bus.mem_addr), 64'h0);
        step();

`ifdef ARB_STATS_EN
        // Stall counter: port 2 waits 8 cycles behind ports 0 and 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 3'b111;
        repeat (8) step();
        @(negedge clk);
        check_eq("st_gnt2",  64'(bus.gnt),            64'h4);
        check_eq("st_cnt2",  64'(stall_cnt[32 +: 16]), 64'd8);
        check_eq("st_cnt1",  64'(stall_cnt[16 +: 16]), 64'd4);
        step();
        bus.req = 3'b000;

        // Saturation: 8 ports, MAX_BURST=1, each port stalls 7 of 8 cycles
        bus8.req = 8'hFF;
        repeat (76000) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("st_sat7", 64'(stall8[7*16 +: 16]), 64'hFFFF);
        check_eq("st_sat0", 64'(stall8[0 +: 16]),    64'hFFFF);
        repeat (10) step();
        @(negedge clk);
        check_eq("st_hold7", 64'(stall8[7*16 +: 16]), 64'hFFFF);
        bus8.req = 8'h00;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
